// File: rtl/video_lcd_spi_target.sv
// rtl/video_lcd_spi_target.sv - oversampled LCD-style 4-wire SPI target with RS-tagged RX FIFO and register bus
module video_lcd_spi_target #(
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_request,
    input  logic        i_rw,
    input  logic [1:0]  i_address,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_ready,
    input  logic        i_spi_cs_n,
    input  logic        i_spi_rs,
    input  logic        i_spi_sck,
    input  logic        i_spi_mosi,
    output logic        o_spi_miso,
    output logic        o_interrupt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        ST_IDLE,
        ST_RESP
    } bus_state_e;

    // SCK and CS carry one extra flop so edges come from the last two synchronized samples
    logic [SYNC_STAGES:0]   sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES:0]   cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] rs_sync_q, rs_sync_d;

    logic       sck_s, sck_p, cs_s, cs_p, mosi_s, rs_s;
    logic       sck_rise, sck_fall, cs_fall, cs_rise;

    // Receiver state; armed_q is set only by a real CS fall, so a reset inside a frame
    // keeps the target deaf until the host reselects it
    logic       armed_q, armed_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic       spi_push;
    logic       abort_set;
    logic [8:0] push_data;

    // FIFO
    logic [8:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
    logic             fifo_empty, fifo_full;
    logic             push_ok, ovf_set;

    // Registers and bus
    logic       overflow_q, overflow_d;
    logic       abort_q, abort_d;
    logic [7:0] tx_reg_q, tx_reg_d;
    logic       irq_en_q, irq_en_d;
    logic [31:0] rdata_q, rdata_d;
    bus_state_e state_q, state_d;

    logic        bus_access;
    logic        do_pop, do_flush;
    logic        wr_status, wr_tx, wr_ctrl;
    logic [31:0] rd_mux;
    logic [31:0] status_word;
    logic        unused_wdata;

    assign unused_wdata = ^i_wdata[31:8];

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign sck_p  = sck_sync_q[SYNC_STAGES];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign cs_p   = cs_sync_q[SYNC_STAGES];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign rs_s   = rs_sync_q[SYNC_STAGES-1];

    assign sck_rise = sck_s && !sck_p;
    assign sck_fall = !sck_s && sck_p;
    assign cs_fall  = !cs_s && cs_p;
    assign cs_rise  = cs_s && !cs_p;

    assign fifo_empty = (fifo_cnt_q == '0);
    assign fifo_full  = (fifo_cnt_q == CNT_W'(FIFO_DEPTH));

    // Shift every SPI input one stage further down its synchronizer chain
    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-1:0], i_spi_sck};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-1:0], i_spi_cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], i_spi_mosi};
        rs_sync_d   = {rs_sync_q[SYNC_STAGES-2:0], i_spi_rs};
    end

    // SPI mode 0 receiver/transmitter: sample on SCK rise, shift MISO on SCK fall
    always_comb begin
        armed_d    = armed_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        spi_push   = 1'b0;
        abort_set  = 1'b0;
        push_data  = {rs_s, rx_shift_q[6:0], mosi_s};
        if (cs_fall) begin
            armed_d    = 1'b1;
            bit_cnt_d  = 3'd0;
            tx_shift_d = tx_reg_q;
        end else if (cs_rise) begin
            if (armed_q && bit_cnt_q != 3'd0) begin
                abort_set = 1'b1;
            end
            armed_d   = 1'b0;
            bit_cnt_d = 3'd0;
        end else if (armed_q && !cs_s) begin
            if (sck_rise) begin
                rx_shift_d = {rx_shift_q[6:0], mosi_s};
                bit_cnt_d  = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    spi_push   = 1'b1;
                    tx_shift_d = tx_reg_q;
                end
            end else if (sck_fall && bit_cnt_q != 3'd0) begin
                tx_shift_d = {tx_shift_q[6:0], 1'b0};
            end
        end
    end

    // Bus decode: the single access of a transaction happens in the IDLE cycle the request is seen
    always_comb begin
        bus_access = (state_q == ST_IDLE) && i_request;
        do_pop     = bus_access && !i_rw && (i_address == 2'd0) && !fifo_empty;
        wr_status  = bus_access && i_rw && (i_address == 2'd1);
        wr_tx      = bus_access && i_rw && (i_address == 2'd2);
        wr_ctrl    = bus_access && i_rw && (i_address == 2'd3);
        do_flush   = wr_ctrl && i_wdata[1];
    end

    // FIFO pointers/count; a push while full is accepted only when a pop frees a slot the same cycle
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        push_ok    = spi_push && !do_flush && (!fifo_full || do_pop);
        ovf_set    = spi_push && !do_flush && fifo_full && !do_pop;
        if (do_flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fifo_cnt_d = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            fifo_cnt_d = fifo_cnt_q + CNT_W'(push_ok) - CNT_W'(do_pop);
        end
    end

    // Sticky flags (set beats write-1-to-clear) and writable registers
    always_comb begin
        overflow_d = overflow_q;
        abort_d    = abort_q;
        tx_reg_d   = tx_reg_q;
        irq_en_d   = irq_en_q;
        if (wr_status && i_wdata[2]) begin
            overflow_d = 1'b0;
        end
        if (wr_status && i_wdata[3]) begin
            abort_d = 1'b0;
        end
        if (ovf_set) begin
            overflow_d = 1'b1;
        end
        if (abort_set) begin
            abort_d = 1'b1;
        end
        if (wr_tx) begin
            tx_reg_d = i_wdata[7:0];
        end
        if (wr_ctrl) begin
            irq_en_d = i_wdata[0];
        end
    end

    // Read data mux
    always_comb begin
        status_word = (32'(fifo_cnt_q) << 8)
                    | {27'd0, armed_q, abort_q, overflow_q, fifo_full, fifo_empty};
        rd_mux = '0;
        case (i_address)
            2'd0:    rd_mux = fifo_empty ? 32'd0 : {1'b1, 22'd0, mem_q[rd_ptr_q]};
            2'd1:    rd_mux = status_word;
            2'd2:    rd_mux = {24'd0, tx_reg_q};
            default: rd_mux = {31'd0, irq_en_q};
        endcase
    end

    // Bus FSM: IDLE performs the access, RESP holds ready until the request drops
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (i_request) begin
                    rdata_d = i_rw ? 32'd0 : rd_mux;
                    state_d = ST_RESP;
                end
            end
            default: begin
                if (!i_request) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // State registers, all cleared asynchronously
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            rs_sync_q   <= '0;
            armed_q     <= 1'b0;
            bit_cnt_q   <= 3'd0;
            rx_shift_q  <= 8'd0;
            tx_shift_q  <= 8'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            overflow_q  <= 1'b0;
            abort_q     <= 1'b0;
            tx_reg_q    <= 8'd0;
            irq_en_q    <= 1'b0;
            rdata_q     <= 32'd0;
            state_q     <= ST_IDLE;
        end else begin
            sck_sync_q  <= sck_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            rs_sync_q   <= rs_sync_d;
            armed_q     <= armed_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            overflow_q  <= overflow_d;
            abort_q     <= abort_d;
            tx_reg_q    <= tx_reg_d;
            irq_en_q    <= irq_en_d;
            rdata_q     <= rdata_d;
            state_q     <= state_d;
        end
    end

    // FIFO storage; contents are only observable through a non-empty read, so no reset
    always_ff @(posedge i_clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign o_rdata     = rdata_q;
    assign o_ready     = i_request && (state_q == ST_RESP);
    assign o_spi_miso  = armed_q && !cs_s && tx_shift_q[7];
    assign o_interrupt = irq_en_q && !fifo_empty;

endmodule
